// File: rtl/if_else_select_pipe.sv
// ============================================================================
// if_else_select_pipe : two-stage valid/ready per-segment if/else selector.
// Optional taken-count statistics via macro IF_ELSE_SELECT_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_else_select_pipe #(
  parameter int DATA_W    = 32,
  parameter int SEGS      = 4,
  parameter int COND_W    = 32,
  parameter int COND_BASE = 0,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COND_W-1:0]        input_bit,
  input  logic [SEGS-1:0]          cond_inv,
  input  logic [SEGS*DATA_W-1:0]   array_ref_wire,
  input  logic [SEGS*DATA_W-1:0]   array_ref_m_wire,
  output logic [SEGS*DATA_W-1:0]   segment_combine,
  output logic [SEGS-1:0]          segment_cond,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     stats_clr,
  output logic [CNT_W-1:0]         taken_cnt
);

  logic                   s1_valid_q, s1_valid_d;
  logic [SEGS-1:0]        s1_cond_q, s1_cond_d;
  logic [SEGS*DATA_W-1:0] s1_if_q, s1_if_d;
  logic [SEGS*DATA_W-1:0] s1_else_q, s1_else_d;
  logic                   out_valid_q, out_valid_d;
  logic [SEGS*DATA_W-1:0] combine_q, combine_d;
  logic [SEGS-1:0]        cond_q, cond_d;
  logic [SEGS*DATA_W-1:0] sel_data;
  logic                   s1_en, s2_en;

  // Condition bits outside the segment window feed nothing.
  logic unused_ok;
  assign unused_ok = ^{input_bit, stats_clr};

  for (genvar k = 0; k < SEGS; k++) begin : g_seg
    assign sel_data[k*DATA_W +: DATA_W] = s1_cond_q[k] ? s1_if_q[k*DATA_W +: DATA_W]
                                                       : s1_else_q[k*DATA_W +: DATA_W];
  end

  always_comb begin
    s2_en       = !out_valid_q || out_ready;
    s1_en       = !s1_valid_q || s2_en;
    s1_valid_d  = s1_valid_q;
    s1_cond_d   = s1_cond_q;
    s1_if_d     = s1_if_q;
    s1_else_d   = s1_else_q;
    out_valid_d = out_valid_q;
    combine_d   = combine_q;
    cond_d      = cond_q;
    // Data registers load only with a real transfer so idle outputs stay quiet.
    if (s1_en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_cond_d = input_bit[COND_BASE +: SEGS] ^ cond_inv;
        s1_if_d   = array_ref_wire;
        s1_else_d = array_ref_m_wire;
      end
    end
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        combine_d = sel_data;
        cond_d    = s1_cond_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_cond_q   <= '0;
      s1_if_q     <= '0;
      s1_else_q   <= '0;
      out_valid_q <= 1'b0;
      combine_q   <= '0;
      cond_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cond_q   <= s1_cond_d;
      s1_if_q     <= s1_if_d;
      s1_else_q   <= s1_else_d;
      out_valid_q <= out_valid_d;
      combine_q   <= combine_d;
      cond_q      <= cond_d;
    end
  end

  assign in_ready        = s1_en;
  assign out_valid       = out_valid_q;
  assign segment_combine = combine_q;
  assign segment_cond    = cond_q;

`ifdef IF_ELSE_SELECT_STATS_EN
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W:0]   pop;
  logic [CNT_W:0]   sum;

  always_comb begin
    pop = '0;
    for (int k = 0; k < SEGS; k++) begin
      pop = pop + {{CNT_W{1'b0}}, cond_q[k]};
    end
    sum         = {1'b0, taken_cnt_q} + pop;
    taken_cnt_d = taken_cnt_q;
    if (stats_clr) begin
      taken_cnt_d = '0;
    end else if (out_valid_q && out_ready) begin
      taken_cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign taken_cnt = taken_cnt_q;
`else
  assign taken_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_else_select_pipe.sv
// Self-checking bench for if_else_select_pipe: queue-based reference model plus directed pins.
`default_nettype none

module tb_if_else_select_pipe;
  localparam int DATA_W = 32;
  localparam int SEGS   = 4;
  localparam int COND_W = 32;
  localparam int CNT_W  = 16;
  localparam int W      = SEGS*DATA_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [COND_W-1:0] input_bit;
  logic [SEGS-1:0]  cond_inv;
  logic [W-1:0]     if_vec, else_vec;
  logic [W-1:0]     segment_combine;
  logic [SEGS-1:0]  segment_cond;
  logic             out_valid;
  logic             out_ready;
  logic             stats_clr;
  logic [CNT_W-1:0] taken_cnt;

  always #5 clk = ~clk;

  if_else_select_pipe #(.DATA_W(DATA_W), .SEGS(SEGS), .COND_W(COND_W), .COND_BASE(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_bit(input_bit), .cond_inv(cond_inv),
    .array_ref_wire(if_vec), .array_ref_m_wire(else_vec),
    .segment_combine(segment_combine), .segment_cond(segment_cond),
    .out_valid(out_valid), .out_ready(out_ready),
    .stats_clr(stats_clr), .taken_cnt(taken_cnt)
  );

`ifdef IF_ELSE_SELECT_STATS_EN
  logic             s_in_ready, s_out_valid;
  logic [W-1:0]     s_combine;
  logic [SEGS-1:0]  s_cond;
  logic [3:0]       s_taken;
  if_else_select_pipe #(.DATA_W(DATA_W), .SEGS(SEGS), .COND_W(COND_W), .COND_BASE(0), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .input_bit(input_bit), .cond_inv(cond_inv),
    .array_ref_wire(if_vec), .array_ref_m_wire(else_vec),
    .segment_combine(s_combine), .segment_cond(s_cond),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .stats_clr(stats_clr), .taken_cnt(s_taken)
  );
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0]    data;
    logic [SEGS-1:0] cond;
    int              e;
  } item_t;

  item_t q[$];
  int    edge_cnt = 0;
  int    consumed = 0;
  bit    started  = 0;
  longint m_cnt   = 0;
  longint m_sat   = 0;

  function automatic bit m_out_valid();
    return (q.size() > 0) && (q[0].e < edge_cnt);
  endfunction

  function automatic bit m_in_ready();
    return !(q.size() >= 2 && !out_ready);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_cnt   = 0;
      m_sat   = 0;
      started = 1;
    end else if (started) begin
      bit acc;
      acc = in_valid && m_in_ready();
      if (m_out_valid() && out_ready) begin
        longint p;
        p = $countones(q[0].cond);
        m_cnt = (m_cnt + p > 65535) ? 65535 : m_cnt + p;
        m_sat = (m_sat + p > 15) ? 15 : m_sat + p;
        void'(q.pop_front());
        consumed++;
      end
      if (stats_clr) begin
        m_cnt = 0;
        m_sat = 0;
      end
      if (acc) begin
        item_t it;
        it.cond = input_bit[SEGS-1:0] ^ cond_inv;
        for (int k = 0; k < SEGS; k++)
          it.data[k*DATA_W +: DATA_W] = it.cond[k] ? if_vec[k*DATA_W +: DATA_W]
                                                   : else_vec[k*DATA_W +: DATA_W];
        it.e = edge_cnt + 1;
        q.push_back(it);
      end
    end
    edge_cnt++;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {127'd0, in_ready}, {127'd0, m_in_ready()});
      chk("out_valid", {127'd0, out_valid}, {127'd0, m_out_valid()});
      if (m_out_valid()) begin
        chk("combine", segment_combine, q[0].data);
        chk("seg_cond", {124'd0, segment_cond}, {124'd0, q[0].cond});
      end
`ifdef IF_ELSE_SELECT_STATS_EN
      chk("taken_cnt", {112'd0, taken_cnt}, 128'(m_cnt));
      chk("taken_sat", {124'd0, s_taken}, 128'(m_sat));
`else
      chk("taken_cnt", {112'd0, taken_cnt}, 128'd0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pat(input logic [15:0] hi);
    logic [W-1:0] v;
    for (int k = 0; k < SEGS; k++) v[k*DATA_W +: DATA_W] = {hi, 16'(k)};
    return v;
  endfunction

  logic [W-1:0] exp_v;
  bit           saw_low;
  int           sent, cyc, c0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; input_bit = '0; cond_inv = '0;
    if_vec = '0; else_vec = '0; out_ready = 1'b1; stats_clr = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_combine", segment_combine, 128'd0);
    chk("rst_cond", {124'd0, segment_cond}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_taken", {112'd0, taken_cnt}, 128'd0);

    // Selection and latency
    input_bit = 32'h5; cond_inv = 4'h0;
    if_vec = pat(16'hAAAA); else_vec = pat(16'hBBBB); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_early", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    exp_v = {32'hBBBB_0003, 32'hAAAA_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    chk("sel_valid", {127'd0, out_valid}, 128'd1);
    chk("sel_combine", segment_combine, exp_v);
    chk("sel_cond", {124'd0, segment_cond}, 128'h5);

    // Inversion
    cond_inv = 4'hF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_v = {32'hAAAA_0003, 32'hBBBB_0002, 32'hAAAA_0001, 32'hBBBB_0000};
    chk("inv_valid", {127'd0, out_valid}, 128'd1);
    chk("inv_combine", segment_combine, exp_v);
    chk("inv_cond", {124'd0, segment_cond}, 128'hA);
    tick();

    // Backpressure: 10 back-to-back, out_ready low for cycles 3..7
    cond_inv = 4'h0; saw_low = 0; sent = 0; cyc = 0; c0 = consumed;
    while (sent < 10 && cyc < 100) begin
      out_ready = !(cyc >= 3 && cyc <= 7);
      in_valid  = 1'b1;
      input_bit = $urandom; cond_inv = 4'($urandom);
      if_vec    = {$urandom, $urandom, $urandom, $urandom};
      else_vec  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (!in_ready) saw_low = 1;
      if (in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    chk("bp_sent", 128'(sent), 128'd10);
    chk("bp_in_ready_low", {127'd0, saw_low}, 128'd1);
    chk("bp_consumed", 128'(consumed - c0), 128'd10);

    // Reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    reset = 1'b0; out_ready = 1'b1;
    repeat (6) tick();

`ifdef IF_ELSE_SELECT_STATS_EN
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    input_bit = 32'h7; cond_inv = 4'h0; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("stats_9", {112'd0, taken_cnt}, 128'd9);
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    @(negedge clk);
    chk("stats_clr", {112'd0, taken_cnt}, 128'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      input_bit = $urandom; cond_inv = 4'($urandom);
      if_vec    = {$urandom, $urandom, $urandom, $urandom};
      else_vec  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
`ifdef IF_ELSE_SELECT_STATS_EN
    @(negedge clk);
    chk("sat_15", {124'd0, s_taken}, 128'd15);
`endif
    chk("drained", 128'(q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
